// File: rtl/seq_det_param.sv
// ----------------------------------------------------------------------------
// seq_det_param
//
// Parametrised serial sequence detector. Bits arrive MSB-of-pattern first on
// seq_in and are accepted only while seq_valid is high. A one-cycle registered
// pulse on det_o marks each detection. A saturating counter, det_count, counts
// detections. The pattern register can be reloaded at run time through
// pat_load/pat_in.
//
// Parameters
//   PAT_W    pattern length in bits (>= 2)
//   PATTERN  reset value of the pattern register (MSB is expected first)
//   CNT_W    width of the detection counter
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   seq_in       in   serial data bit
//   seq_valid    in   seq_in is sampled only when high
//   overlap      in   1 = overlapping detection, 0 = non-overlapping
//   pat_load     in   load pat_in into the pattern register (wins over data)
//   pat_in       in   new pattern value [PAT_W]
//   clear_count  in   synchronous clear of det_count (wins over increment)
//   det_o        out  registered one-cycle detect pulse
//   det_count    out  saturating detection count [CNT_W]
// ----------------------------------------------------------------------------
module seq_det_param #(
  parameter int unsigned         PAT_W   = 4,
  parameter logic [PAT_W-1:0]    PATTERN = 4'b1011,
  parameter int unsigned         CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             seq_in,
  input  logic             seq_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             clear_count,
  output logic             det_o,
  output logic [CNT_W-1:0] det_count
);

  // Fill counter spans 0..PAT_W-1; keep at least one bit for PAT_W = 2.
  localparam int unsigned       FILL_W    = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_ARMED   = 2'd2
  } state_e;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [PAT_W-1:0]  pat_q,   pat_d;
  logic [PAT_W-2:0]  hist_q,  hist_d;
  logic [FILL_W-1:0] fill_q,  fill_d;
  state_e            state_q, state_d;
  logic              det_q,   det_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  // --------------------------------------------------------------------------
  // Accept / match qualification
  // --------------------------------------------------------------------------
  logic             accept;
  logic [PAT_W-1:0] cand;
  logic             hit;

  // A pattern load takes the whole edge, so the data bit is not accepted.
  assign accept = seq_valid & ~pat_load;

  // Candidate word: accepted history followed by the bit on the line now.
  // Its low PAT_W-1 bits are also the shifted history.
  assign cand = {hist_q, seq_in};

  // Only a fully filled history can form a genuine match; this keeps the
  // all-zero reset history from matching an all-zero pattern early.
  assign hit = accept && (state_q == ST_ARMED) && (cand == pat_q);

  // Map a fill level to its FSM state.
  function automatic state_e state_of(input logic [FILL_W-1:0] fill);
    state_e st;
    if (fill == '0) begin
      st = ST_EMPTY;
    end else if (fill == FILL_FULL) begin
      st = ST_ARMED;
    end else begin
      st = ST_FILLING;
    end
    return st;
  endfunction

  // --------------------------------------------------------------------------
  // Next-state logic for FSM and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    state_d = state_q;
    det_d   = 1'b0;

    if (pat_load) begin
      // New pattern: drop all partial progress.
      pat_d   = pat_in;
      hist_d  = '0;
      fill_d  = '0;
      state_d = ST_EMPTY;
    end else if (accept) begin
      if (hit) begin
        det_d = 1'b1;
        if (overlap) begin
          // Keep the tail of the matched word; fill is already full.
          hist_d  = cand[PAT_W-2:0];
          fill_d  = FILL_FULL;
          state_d = ST_ARMED;
        end else begin
          // No bit of the matched word may contribute to the next one.
          hist_d  = '0;
          fill_d  = '0;
          state_d = ST_EMPTY;
        end
      end else begin
        hist_d = cand[PAT_W-2:0];
        if (fill_q != FILL_FULL) begin
          fill_d = fill_q + FILL_ONE;
        end
        state_d = state_of(fill_d);
      end
    end
  end

  // Counter: clear has priority over a same-edge detection, then saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_count) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pat_q   <= PATTERN;
      hist_q  <= '0;
      fill_q  <= '0;
      state_q <= ST_EMPTY;
      det_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      state_q <= state_d;
      det_q   <= det_d;
      cnt_q   <= cnt_d;
    end
  end

  assign det_o     = det_q;
  assign det_count = cnt_q;

endmodule
